step_input_conditioner: RTL

- Front-end stage that drives the sequence-detector top (seq_top) from raw board inputs.
- Synchronises and debounces the raw "next" pushbutton and emits exactly one single-cycle step strobe per physical press.
- Synchronises the raw "in" switch and captures it on the same cycle as the strobe, so the detector sees one clean (step, bit) pair per press.
- Outputs connect directly to seq_top's next/in inputs; debug outputs go to LEDs.

---
 rtl/step_input_conditioner_if.sv | 28 ++
 rtl/step_input_conditioner.sv | 128 ++++++++++++
 2 files changed

// File: rtl/step_input_conditioner_if.sv
// Board-side signal bundle between raw pushbutton/switch inputs and the conditioned
// step/bit outputs that feed seq_top, plus the debug LED outputs.
interface step_input_conditioner_if;
    logic       next_raw;
    logic       in_raw;
    logic       step;
    logic       in_sampled;
    logic       pressed;
    logic [1:0] cond_state;

    modport master (
        output next_raw,
        output in_raw,
        input  step,
        input  in_sampled,
        input  pressed,
        input  cond_state
    );

    modport slave (
        input  next_raw,
        input  in_raw,
        output step,
        output in_sampled,
        output pressed,
        output cond_state
    );
endinterface

// File: rtl/step_input_conditioner.sv
// Synchronises and debounces the "next" pushbutton into one step strobe per press,
// and captures the synchronised "in" switch on that same cycle.
module step_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    step_input_conditioner_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_next_s1;
    logic             r_next_s2;
    logic             r_in_s1;
    logic             r_in_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;
    logic             r_in_sampled;
    logic             r_pressed;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_step_nxt;
    logic             w_in_sampled_nxt;
    logic             w_pressed_nxt;

    // Synchroniser chains, FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_s1    <= 1'b0;
            r_next_s2    <= 1'b0;
            r_in_s1      <= 1'b0;
            r_in_s2      <= 1'b0;
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_step       <= 1'b0;
            r_in_sampled <= 1'b0;
            r_pressed    <= 1'b0;
        end else begin
            r_next_s1    <= bus.next_raw;
            r_next_s2    <= r_next_s1;
            r_in_s1      <= bus.in_raw;
            r_in_s2      <= r_in_s1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_step       <= w_step_nxt;
            r_in_sampled <= w_in_sampled_nxt;
            r_pressed    <= w_pressed_nxt;
        end
    end

    // Next-state and next-output logic; the counter only ever reaches CNT_LAST
    // while qualifying, where the FSM leaves the wait state, so it cannot wrap.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_step_nxt       = 1'b0;
        w_in_sampled_nxt = r_in_sampled;
        w_pressed_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_next_s2) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_next_s2) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt      = ST_HELD;
                    w_step_nxt       = 1'b1;
                    w_in_sampled_nxt = r_in_s2;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!r_next_s2) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_next_s2) begin
                    w_state_nxt = ST_HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase

        if ((w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_WAIT)) begin
            w_pressed_nxt = 1'b1;
        end else begin
            w_pressed_nxt = 1'b0;
        end
    end

    assign bus.step       = r_step;
    assign bus.in_sampled = r_in_sampled;
    assign bus.pressed    = r_pressed;
    assign bus.cond_state = r_state;

endmodule
